// File: rtl/motor_pkg.sv
// Shared definitions for the motor speed scheduler and its consumers.
//   - motor_state_t : scheduler state encoding (IDLE, ARMING, RUN, RAMPDN)
//   - SPD_W         : width of one ESC speed word
//   - *_DEF         : default timing/limit constants, also used by the
//                     flight controller so both sides agree on the numbers.
package motor_pkg;

  localparam int SPD_W = 11;

  // 20 ms update period at 50 MHz.
  localparam int PERIOD_DEF    = 1000000;
  localparam int STEP_DEF      = 16;
  localparam int IDLE_SPD_DEF  = 100;
  localparam int ARM_TICKS_DEF = 50;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    RUN    = 2'd2,
    RAMPDN = 2'd3
  } motor_state_t;

  typedef logic [SPD_W-1:0] spd_t;

endpackage

// File: rtl/slew_chan.sv
// One channel of the slew-rate limiter (purely combinational).
// Moves cur toward tgt by at most STEP per evaluation, never overshooting.
//   cur : current registered speed word
//   tgt : effective target for this update
//   nxt : speed word to load at the next update
module slew_chan
  import motor_pkg::*;
#(
  parameter int DATA_W = SPD_W,
  parameter int STEP   = STEP_DEF
) (
  input  logic [DATA_W-1:0] cur,
  input  logic [DATA_W-1:0] tgt,
  output logic [DATA_W-1:0] nxt
);

  localparam logic signed [DATA_W:0] STEP_S = (DATA_W + 1)'(STEP);

  // One extra bit keeps the difference exact across the full 0..max range.
  logic signed [DATA_W:0] diff;
  logic signed [DATA_W:0] delta;

  function automatic logic signed [DATA_W:0] clamp_step(input logic signed [DATA_W:0] d);
    if (d > STEP_S) begin
      return STEP_S;
    end else if (d < -STEP_S) begin
      return -STEP_S;
    end else begin
      return d;
    end
  endfunction

  assign diff  = $signed({1'b0, tgt}) - $signed({1'b0, cur});
  assign delta = clamp_step(diff);
  // cur + delta always lies between cur and tgt, so the top bit is zero.
  assign nxt   = DATA_W'($signed({1'b0, cur}) + delta);

endmodule

// File: rtl/motor_slew_sched.sv
// Motor speed scheduler feeding the four-channel ESC PWM stage.
// Handles arming, soft spin-up at idle speed, per-channel slew limiting,
// controlled spin-down and emergency kill. Speed words change only on the
// edge that ends a period, and wrt flags the following cycle.
//   clk, rst                     : clock, async active-high reset
//   frnt/bck/lft/rght_tgt, tgt_vld : mixer targets, loaded on the strobe
//   arm, kill                    : arm request level, emergency stop level
//   frnt/bck/lft/rght_spd        : registered speed words
//   wrt                          : one-cycle update strobe
//   motors_off                   : forces ESC outputs to zero
//   at_tgt                       : RUN with every channel on its target
module motor_slew_sched
  import motor_pkg::*;
#(
  parameter int PERIOD    = PERIOD_DEF,
  parameter int STEP      = STEP_DEF,
  parameter int IDLE_SPD  = IDLE_SPD_DEF,
  parameter int ARM_TICKS = ARM_TICKS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SPD_W-1:0] frnt_tgt,
  input  logic [SPD_W-1:0] bck_tgt,
  input  logic [SPD_W-1:0] lft_tgt,
  input  logic [SPD_W-1:0] rght_tgt,
  input  logic             tgt_vld,
  input  logic             arm,
  input  logic             kill,
  output logic [SPD_W-1:0] frnt_spd,
  output logic [SPD_W-1:0] bck_spd,
  output logic [SPD_W-1:0] lft_spd,
  output logic [SPD_W-1:0] rght_spd,
  output logic             wrt,
  output logic             motors_off,
  output logic             at_tgt
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int ARM_W = $clog2(ARM_TICKS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TICKS - 1);
  localparam spd_t             IDLE_V   = SPD_W'(IDLE_SPD);

  motor_state_t     state;
  logic [CNT_W-1:0] cnt;
  logic [ARM_W-1:0] arm_cnt;
  logic             kill_lat;
  logic             tick;

  spd_t spd      [4];
  spd_t shd      [4];
  spd_t eff      [4];
  spd_t slew_tgt [4];
  spd_t nxt      [4];

  logic all_zero;
  logic nxt_on_tgt;
  logic idle_on_tgt;

  // While armed the motors never drop below idle speed.
  function automatic spd_t floor_idle(input spd_t t);
    return (t > IDLE_V) ? t : IDLE_V;
  endfunction

  assign tick = (cnt == CNT_LAST);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      eff[i]      = floor_idle(shd[i]);
      slew_tgt[i] = (state == RAMPDN) ? '0 : eff[i];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_chan
    slew_chan #(
      .DATA_W (SPD_W),
      .STEP   (STEP)
    ) u_slew (
      .cur (spd[g]),
      .tgt (slew_tgt[g]),
      .nxt (nxt[g])
    );
  end

  always_comb begin
    all_zero    = 1'b1;
    nxt_on_tgt  = 1'b1;
    idle_on_tgt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (spd[i] != '0)     all_zero    = 1'b0;
      if (nxt[i] != eff[i]) nxt_on_tgt  = 1'b0;
      if (IDLE_V != eff[i]) idle_on_tgt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      arm_cnt    <= '0;
      kill_lat   <= 1'b0;
      wrt        <= 1'b0;
      motors_off <= 1'b1;
      at_tgt     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        spd[i] <= '0;
        shd[i] <= '0;
      end
    end else begin
      wrt <= tick;
      cnt <= tick ? '0 : cnt + 1'b1;

      // A load coinciding with a tick is seen by the slew logic one tick later.
      if (tgt_vld) begin
        shd[0] <= frnt_tgt;
        shd[1] <= bck_tgt;
        shd[2] <= lft_tgt;
        shd[3] <= rght_tgt;
      end

      if (kill) begin
        // Kill acts immediately and latches; re-arm needs arm dropped at a tick.
        state      <= IDLE;
        motors_off <= 1'b1;
        arm_cnt    <= '0;
        kill_lat   <= 1'b1;
        at_tgt     <= 1'b0;
        for (int i = 0; i < 4; i++) spd[i] <= '0;
      end else if (tick) begin
        if (!arm) kill_lat <= 1'b0;

        unique case (state)
          IDLE: begin
            if (arm && !kill_lat) begin
              state      <= ARMING;
              motors_off <= 1'b0;
              arm_cnt    <= '0;
              for (int i = 0; i < 4; i++) spd[i] <= IDLE_V;
            end
          end

          ARMING: begin
            if (!arm) begin
              state      <= IDLE;
              motors_off <= 1'b1;
              arm_cnt    <= '0;
              for (int i = 0; i < 4; i++) spd[i] <= '0;
            end else if (arm_cnt == ARM_LAST) begin
              state   <= RUN;
              arm_cnt <= '0;
              at_tgt  <= idle_on_tgt;
            end else begin
              arm_cnt <= arm_cnt + 1'b1;
            end
          end

          RUN: begin
            // Dropping arm holds the speeds for this tick; ramp-down starts next.
            if (!arm) begin
              state  <= RAMPDN;
              at_tgt <= 1'b0;
            end else begin
              for (int i = 0; i < 4; i++) spd[i] <= nxt[i];
              at_tgt <= nxt_on_tgt;
            end
          end

          RAMPDN: begin
            if (all_zero) begin
              state      <= IDLE;
              motors_off <= 1'b1;
            end else begin
              for (int i = 0; i < 4; i++) spd[i] <= nxt[i];
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign frnt_spd = spd[0];
  assign bck_spd  = spd[1];
  assign lft_spd  = spd[2];
  assign rght_spd = spd[3];

endmodule

// File: tb/tb_motor_slew_sched.sv
// Directed bench for motor_slew_sched with PERIOD=8, STEP=16,
// IDLE_SPD=100, ARM_TICKS=2.
module tb_motor_slew_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] frnt_tgt = '0;
  logic [10:0] bck_tgt  = '0;
  logic [10:0] lft_tgt  = '0;
  logic [10:0] rght_tgt = '0;
  logic        tgt_vld  = 1'b0;
  logic        arm      = 1'b0;
  logic        kill     = 1'b0;
  logic [10:0] frnt_spd, bck_spd, lft_spd, rght_spd;
  logic        wrt, motors_off, at_tgt;

  int checks   = 0;
  int failures = 0;

  motor_slew_sched #(
    .PERIOD    (8),
    .STEP      (16),
    .IDLE_SPD  (100),
    .ARM_TICKS (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frnt_tgt   (frnt_tgt),
    .bck_tgt    (bck_tgt),
    .lft_tgt    (lft_tgt),
    .rght_tgt   (rght_tgt),
    .tgt_vld    (tgt_vld),
    .arm        (arm),
    .kill       (kill),
    .frnt_spd   (frnt_spd),
    .bck_spd    (bck_spd),
    .lft_spd    (lft_spd),
    .rght_spd   (rght_spd),
    .wrt        (wrt),
    .motors_off (motors_off),
    .at_tgt     (at_tgt)
  );

  always #5 clk = ~clk;

  // Advance to the next negedge at which wrt is high, bounded.
  task automatic wait_wrt(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (wrt !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wrt !== 1'b1) begin
      failures++;
      $display("FAIL %s wrt_timeout: wrt=%b required 1", tag, wrt);
    end
  endtask

  task automatic load_tgts(input logic [10:0] f, input logic [10:0] b,
                           input logic [10:0] l, input logic [10:0] r);
    frnt_tgt = f; bck_tgt = b; lft_tgt = l; rght_tgt = r;
    tgt_vld  = 1'b1;
    @(negedge clk);
    tgt_vld  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (frnt_spd !== 11'd0 || bck_spd !== 11'd0 || lft_spd !== 11'd0 || rght_spd !== 11'd0) begin
      failures++;
      $display("FAIL reset_spd: %0d %0d %0d %0d required 0", frnt_spd, bck_spd, lft_spd, rght_spd);
    end
    checks++;
    if (motors_off !== 1'b1) begin
      failures++;
      $display("FAIL reset_motors_off: %b required 1", motors_off);
    end
    checks++;
    if (wrt !== 1'b0 || at_tgt !== 1'b0) begin
      failures++;
      $display("FAIL reset_wrt_at_tgt: wrt=%b at_tgt=%b required 0 0", wrt, at_tgt);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int last = -1;
    int n    = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      checks++;
      if (motors_off !== 1'b1 || frnt_spd !== 11'd0 || bck_spd !== 11'd0 ||
          lft_spd !== 11'd0 || rght_spd !== 11'd0) begin
        failures++;
        $display("FAIL idle_state c=%0d: motors_off=%b spd=%0d/%0d/%0d/%0d required 1 and 0",
                 c, motors_off, frnt_spd, bck_spd, lft_spd, rght_spd);
      end
      if (wrt === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 8) begin
            failures++;
            $display("FAIL idle_wrt_gap: gap=%0d required 8", c - last);
          end
        end
        last = c;
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      failures++;
      $display("FAIL idle_wrt_count: count=%0d required 5", n);
    end
  endtask

  task automatic test_arm();
    logic [10:0] exp_spd [11];
    logic        exp_at  [11];
    exp_spd = '{11'd100, 11'd100, 11'd100, 11'd116, 11'd132, 11'd148,
                11'd164, 11'd180, 11'd196, 11'd200, 11'd200};
    exp_at  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wait_wrt("arm_sync");
    arm = 1'b1;
    load_tgts(11'd200, 11'd200, 11'd200, 11'd200);
    for (int k = 0; k < 11; k++) begin
      wait_wrt("arm");
      checks++;
      if (frnt_spd !== exp_spd[k] || bck_spd !== exp_spd[k] ||
          lft_spd !== exp_spd[k] || rght_spd !== exp_spd[k]) begin
        failures++;
        $display("FAIL arm_spd[%0d]: %0d/%0d/%0d/%0d required %0d",
                 k, frnt_spd, bck_spd, lft_spd, rght_spd, exp_spd[k]);
      end
      checks++;
      if (motors_off !== 1'b0) begin
        failures++;
        $display("FAIL arm_motors_off[%0d]: %b required 0", k, motors_off);
      end
      checks++;
      if (at_tgt !== exp_at[k]) begin
        failures++;
        $display("FAIL arm_at_tgt[%0d]: %b required %b", k, at_tgt, exp_at[k]);
      end
    end
  endtask

  task automatic test_rampdown();
    logic [10:0] e;
    logic        mo;
    int          v;
    arm = 1'b0;
    for (int i = 0; i < 15; i++) begin
      wait_wrt("rampdn");
      v  = (i == 0) ? 200 : 200 - 16 * i;
      e  = (v > 0) ? 11'(v) : 11'd0;
      mo = (i == 14);
      checks++;
      if (frnt_spd !== e || bck_spd !== e || lft_spd !== e || rght_spd !== e) begin
        failures++;
        $display("FAIL rampdn_spd[%0d]: %0d/%0d/%0d/%0d required %0d",
                 i, frnt_spd, bck_spd, lft_spd, rght_spd, e);
      end
      checks++;
      if (motors_off !== mo) begin
        failures++;
        $display("FAIL rampdn_motors_off[%0d]: %b required %b", i, motors_off, mo);
      end
    end
  endtask

  task automatic test_rearm();
    arm = 1'b1;
    repeat (10) wait_wrt("rearm");
    checks++;
    if (frnt_spd !== 11'd200 || rght_spd !== 11'd200 || at_tgt !== 1'b1 || motors_off !== 1'b0) begin
      failures++;
      $display("FAIL rearm: frnt=%0d rght=%0d at_tgt=%b motors_off=%b required 200 200 1 0",
               frnt_spd, rght_spd, at_tgt, motors_off);
    end
  endtask

  task automatic test_clamp();
    int ef = 200;
    int eb = 200;
    logic ea;
    load_tgts(11'h7FF, 11'd0, 11'd200, 11'd200);
    for (int k = 0; k < 117; k++) begin
      wait_wrt("clamp");
      ef = (ef + 16 > 2047) ? 2047 : ef + 16;
      eb = (eb - 16 < 100) ? 100 : eb - 16;
      ea = (ef == 2047) && (eb == 100);
      checks++;
      if (frnt_spd !== 11'(ef) || bck_spd !== 11'(eb) || lft_spd !== 11'd200) begin
        failures++;
        $display("FAIL clamp_spd[%0d]: frnt=%0d bck=%0d lft=%0d required %0d %0d 200",
                 k, frnt_spd, bck_spd, lft_spd, ef, eb);
      end
      checks++;
      if (at_tgt !== ea) begin
        failures++;
        $display("FAIL clamp_at_tgt[%0d]: %b required %b", k, at_tgt, ea);
      end
    end
  endtask

  task automatic test_same_tick();
    // On the wrt negedge the counter reads 0; seven negedges later is the tick cycle.
    repeat (7) @(negedge clk);
    load_tgts(11'd300, 11'd300, 11'd300, 11'd300);
    checks++;
    if (wrt !== 1'b1 || frnt_spd !== 11'd2047 || bck_spd !== 11'd100 ||
        lft_spd !== 11'd200 || at_tgt !== 1'b1) begin
      failures++;
      $display("FAIL same_tick_old: wrt=%b frnt=%0d bck=%0d lft=%0d at_tgt=%b required 1 2047 100 200 1",
               wrt, frnt_spd, bck_spd, lft_spd, at_tgt);
    end
    wait_wrt("same_tick");
    checks++;
    if (frnt_spd !== 11'd2031 || bck_spd !== 11'd116 || lft_spd !== 11'd216 ||
        rght_spd !== 11'd216 || at_tgt !== 1'b0) begin
      failures++;
      $display("FAIL same_tick_new: %0d/%0d/%0d/%0d at_tgt=%b required 2031/116/216/216 0",
               frnt_spd, bck_spd, lft_spd, rght_spd, at_tgt);
    end
  endtask

  task automatic test_kill();
    kill = 1'b1;
    @(negedge clk);
    checks++;
    if (frnt_spd !== 11'd0 || bck_spd !== 11'd0 || lft_spd !== 11'd0 || rght_spd !== 11'd0 ||
        motors_off !== 1'b1 || at_tgt !== 1'b0) begin
      failures++;
      $display("FAIL kill_immediate: %0d/%0d/%0d/%0d motors_off=%b at_tgt=%b required 0s 1 0",
               frnt_spd, bck_spd, lft_spd, rght_spd, motors_off, at_tgt);
    end
    repeat (2) wait_wrt("kill_held");
    checks++;
    if (motors_off !== 1'b1 || frnt_spd !== 11'd0) begin
      failures++;
      $display("FAIL kill_held: motors_off=%b frnt=%0d required 1 0", motors_off, frnt_spd);
    end
    kill = 1'b0;
    repeat (2) wait_wrt("kill_latched");
    checks++;
    if (motors_off !== 1'b1 || frnt_spd !== 11'd0) begin
      failures++;
      $display("FAIL kill_latched: motors_off=%b frnt=%0d required 1 0", motors_off, frnt_spd);
    end
    arm = 1'b0;
    wait_wrt("kill_clear");
    checks++;
    if (motors_off !== 1'b1) begin
      failures++;
      $display("FAIL kill_clear: motors_off=%b required 1", motors_off);
    end
    arm = 1'b1;
    wait_wrt("kill_rearm");
    checks++;
    if (motors_off !== 1'b0 || frnt_spd !== 11'd100 || bck_spd !== 11'd100) begin
      failures++;
      $display("FAIL kill_rearm: motors_off=%b frnt=%0d bck=%0d required 0 100 100",
               motors_off, frnt_spd, bck_spd);
    end
  endtask

  task automatic test_reset_mid_ramp();
    repeat (3) wait_wrt("mid_ramp");
    checks++;
    if (frnt_spd !== 11'd116 || wrt !== 1'b1) begin
      failures++;
      $display("FAIL mid_ramp_pre: frnt=%0d wrt=%b required 116 1", frnt_spd, wrt);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (frnt_spd !== 11'd0 || bck_spd !== 11'd0 || lft_spd !== 11'd0 || rght_spd !== 11'd0 ||
        wrt !== 1'b0 || motors_off !== 1'b1 || at_tgt !== 1'b0) begin
      failures++;
      $display("FAIL mid_ramp_reset: %0d/%0d/%0d/%0d wrt=%b motors_off=%b at_tgt=%b required 0s 0 1 0",
               frnt_spd, bck_spd, lft_spd, rght_spd, wrt, motors_off, at_tgt);
    end
    @(negedge clk);
    rst = 1'b0;
    arm = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_arm();
    test_rampdown();
    test_rearm();
    test_clamp();
    test_same_tick();
    test_kill();
    test_reset_mid_ramp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
